ctrl_event_gen: RTL



---
 rtl/ctrl_event_gen_pkg.sv | 33 +++
 rtl/ctrl_event_gen_nav_repeat.sv | 65 ++++++
 rtl/ctrl_event_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ctrl_event_gen_pkg.sv
// Shared controller-word bit map, default combos and helpers for ctrl_event_gen.
package ctrl_event_gen_pkg;

  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_DU = 4;
  localparam int BTN_DD = 5;
  localparam int BTN_DL = 6;
  localparam int BTN_DR = 7;

  // Joystick-reset and the unused bit never reach the button word.
  localparam logic [15:0] BTN_MASK      = 16'hFCFF;
  localparam logic [15:0] IGR_COMBO_DEF = 16'h0C0C;
  localparam logic [15:0] OSD_COMBO_DEF = 16'h0C80;

  localparam int NUM_NAV  = 6;
  localparam int NAV_UP   = 0;
  localparam int NAV_DOWN = 1;
  localparam int NAV_LEFT = 2;
  localparam int NAV_RGHT = 3;
  localparam int NAV_OK   = 4;
  localparam int NAV_BACK = 5;

  typedef enum logic [1:0] {C_IDLE, C_COUNT, C_FIRED} combo_st_e;

  // Stick bytes arrive LSB-first on the wire; lowest bit is the sign.
  function automatic logic signed [8:0] stick9(input logic [7:0] raw);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = raw[7-i];
    return {r[7], r};
  endfunction

endpackage

// File: rtl/ctrl_event_gen_nav_repeat.sv
// One navigation direction: press pulse plus hold autorepeat, gated by a mask.
module nav_repeat #(
  parameter logic [5:0] REPEAT_DELAY = 6'd20,
  parameter logic [5:0] REPEAT_RATE  = 6'd4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic poll_i,
  input  logic level_i,
  input  logic mask_i,
  output logic pulse_o
);

  localparam logic [6:0] RD   = {1'b0, REPEAT_DELAY};
  localparam logic [6:0] WRAP = RD + {1'b0, REPEAT_RATE};

  logic       lvl_q, lvl_d, blk_q, blk_d, pulse_q, pulse_d;
  logic [6:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    lvl_d   = lvl_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    cnt_inc = cnt_q + 7'd1;
    // Once past the delay the count cycles inside [RD, WRAP).
    if (cnt_inc == WRAP) cnt_inc = RD;
    if (poll_i) begin
      if (!level_i) begin
        lvl_d = 1'b0;
        blk_d = 1'b0;
        cnt_d = '0;
      end else if (mask_i) begin
        // Held under a combo: remember it so it needs a fresh press later.
        lvl_d = 1'b1;
        blk_d = 1'b1;
        cnt_d = '0;
      end else if (!lvl_q) begin
        lvl_d   = 1'b1;
        cnt_d   = '0;
        pulse_d = 1'b1;
      end else if (!blk_q) begin
        cnt_d   = cnt_inc;
        pulse_d = (cnt_inc == RD);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_q   <= 1'b0;
      blk_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      lvl_q   <= lvl_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/ctrl_event_gen.sv
// Controller event generator: IGR/OSD hold combos, menu nav pulses, poll watchdog.
module ctrl_event_gen
  import ctrl_event_gen_pkg::*;
#(
  parameter logic [7:0]  HOLD_POLLS   = 8'd30,
  parameter logic [5:0]  REPEAT_DELAY = 6'd20,
  parameter logic [5:0]  REPEAT_RATE  = 6'd4,
  parameter logic [7:0]  STICK_TH     = 8'd40,
  parameter logic [19:0] TIMEOUT_CYC  = 20'd400000,
  parameter logic [15:0] IGR_COMBO    = IGR_COMBO_DEF,
  parameter logic [15:0] OSD_COMBO    = OSD_COMBO_DEF
) (
  input  logic        CTRL_CLK,
  input  logic        CTRL_RST,
  input  logic [31:0] ctrl_data_i,
  input  logic        ctrl_valid_i,
  input  logic        igr_en_i,
  input  logic        osd_en_i,
  output logic        igr_trigger_o,
  output logic        osd_toggle_o,
  output logic [5:0]  nav_o,
  output logic [15:0] buttons_o,
  output logic        timeout_o
);

  logic [15:0]       btn;
  logic signed [8:0] sx, sy, th_p, th_n;

  assign btn  = ctrl_data_i[15:0] & BTN_MASK;
  assign sx   = stick9(ctrl_data_i[23:16]);
  assign sy   = stick9(ctrl_data_i[31:24]);
  assign th_p = $signed({1'b0, STICK_TH});
  assign th_n = -th_p;

  // Watchdog: wd_sat is the one cycle where the counter reaches its limit.
  logic [19:0] wd_cnt_q, wd_cnt_d;
  logic        wd_sat, timeout_q;
  logic [15:0] buttons_q;

  assign wd_sat = !ctrl_valid_i && (wd_cnt_q == TIMEOUT_CYC - 20'd1);

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (ctrl_valid_i)                 wd_cnt_d = '0;
    else if (wd_cnt_q != TIMEOUT_CYC) wd_cnt_d = wd_cnt_q + 20'd1;
  end

  always_ff @(posedge CTRL_CLK) begin
    if (CTRL_RST) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
      buttons_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (ctrl_valid_i) begin
        timeout_q <= 1'b0;
        buttons_q <= btn;
      end else if (wd_sat) begin
        timeout_q <= 1'b1;
        buttons_q <= '0;
      end
    end
  end

  // Combo FSMs: index 0 is IGR, index 1 is OSD.
  logic [1:0] busy, fire;

  for (genvar g = 0; g < 2; g++) begin : g_combo
    combo_st_e  st_q, st_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fire_q, fire_d, en, hit;

    assign en  = (g == 0) ? igr_en_i : osd_en_i;
    assign hit = (btn == ((g == 0) ? IGR_COMBO : OSD_COMBO));

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      fire_d = 1'b0;
      if (!en || wd_sat) begin
        st_d  = C_IDLE;
        cnt_d = '0;
      end else if (ctrl_valid_i) begin
        unique case (st_q)
          C_IDLE:  if (hit) begin st_d = C_COUNT; cnt_d = 8'd1; end
          C_COUNT: if (hit) cnt_d = cnt_q + 8'd1;
                   else begin st_d = C_IDLE; cnt_d = '0; end
          C_FIRED: if (!hit) begin st_d = C_IDLE; cnt_d = '0; end
          default: st_d = C_IDLE;
        endcase
        if (st_d == C_COUNT && cnt_d == HOLD_POLLS) begin
          st_d   = C_FIRED;
          fire_d = 1'b1;
        end
      end
    end

    always_ff @(posedge CTRL_CLK) begin
      if (CTRL_RST) begin
        st_q   <= C_IDLE;
        cnt_q  <= '0;
        fire_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        fire_q <= fire_d;
      end
    end

    // Include the next state so the poll that starts a combo is masked too.
    assign busy[g] = (st_q != C_IDLE) || (st_d != C_IDLE);
    assign fire[g] = fire_q;
  end

  logic [NUM_NAV-1:0] nav_lvl, nav_pulse;
  logic               nav_mask, nav_rst;

  assign nav_lvl[NAV_UP]   = btn[BTN_DU] | (sy >= th_p);
  assign nav_lvl[NAV_DOWN] = btn[BTN_DD] | (sy <= th_n);
  assign nav_lvl[NAV_LEFT] = btn[BTN_DL] | (sx <= th_n);
  assign nav_lvl[NAV_RGHT] = btn[BTN_DR] | (sx >= th_p);
  assign nav_lvl[NAV_OK]   = btn[BTN_A];
  assign nav_lvl[NAV_BACK] = btn[BTN_B];

  assign nav_mask = (|busy) | !osd_en_i;
  assign nav_rst  = CTRL_RST | wd_sat;

  nav_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_nav [NUM_NAV-1:0] (
    .clk_i   (CTRL_CLK),
    .rst_i   (nav_rst),
    .poll_i  (ctrl_valid_i),
    .level_i (nav_lvl),
    .mask_i  (nav_mask),
    .pulse_o (nav_pulse)
  );

  assign igr_trigger_o = fire[0];
  assign osd_toggle_o  = fire[1];
  assign nav_o         = nav_pulse;
  assign buttons_o     = buttons_q;
  assign timeout_o     = timeout_q;

endmodule
